// File: rtl/irq_nest_ctrl_pkg.sv
// rtl/irq_nest_ctrl_pkg.sv - shared interrupt sizing constants
// Constants shared by the interrupt controller and the ISR entrance lookup,
// so interrupt numbers and return addresses agree on both ends.
package irq_nest_ctrl_pkg;

  // number of interrupt lines, line 0 highest priority
  localparam int IRQ_NIRQ      = 3;
  // interrupt number width, 2**IRQ_NBIT_IRQ > IRQ_NIRQ so the idle level fits
  localparam int IRQ_NBIT_IRQ  = 2;
  // instruction-memory word-address width
  localparam int IRQ_ADDR_NBIT = 10;

endpackage

// File: rtl/irq_edge_sync.sv
// rtl/irq_edge_sync.sv - per-line 2-flop synchroniser with rising-edge pulse
// Ports:
//   clk    in   system clock
//   rst_n  in   asynchronous active-low reset
//   src    in   raw asynchronous interrupt source
//   rise   out  one-cycle pulse on a synchronised 0->1 transition
module irq_edge_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic src,
  output logic rise
);

  logic       s1;
  logic       s2;
  logic       prev;
  logic [1:0] warm;

  // The synchroniser flops come out of reset at 0, so the first two s2
  // samples after reset do not reflect the pin. prev is forced high until
  // s2 carries a real sample; a line held high across reset release must
  // therefore fall and rise again before it is seen as an edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1   <= 1'b0;
      s2   <= 1'b0;
      prev <= 1'b1;
      warm <= 2'b00;
    end else begin
      s1   <= src;
      s2   <= s1;
      warm <= {warm[0], 1'b1};
      prev <= s2 | ~warm[1];
    end
  end

  assign rise = s2 & ~prev;

endmodule

// File: rtl/irq_nest_ctrl.sv
// rtl/irq_nest_ctrl.sv - interrupt request, priority nesting and return-address stack
// Ports:
//   clk, rst_n    clock, asynchronous active-low reset
//   irq_src       raw interrupt sources (rising edge sets pending)
//   irq_en        global enable, irq_mask per-line mask (1 = masked)
//   irq_req       request to core, irq_inum its interrupt number
//   irq_ack       core takes the request, pc_ret return address sampled with it
//   eret          return from interrupt, epc return address at stack top
//   in_isr        stack non-empty, pending flags, err sticky protocol error
module irq_nest_ctrl
  import irq_nest_ctrl_pkg::*;
#(
  parameter int NIRQ      = IRQ_NIRQ,
  parameter int NBIT_IRQ  = IRQ_NBIT_IRQ,
  parameter int ADDR_NBIT = IRQ_ADDR_NBIT
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NIRQ-1:0]      irq_src,
  input  logic                 irq_en,
  input  logic [NIRQ-1:0]      irq_mask,
  output logic                 irq_req,
  output logic [NBIT_IRQ-1:0]  irq_inum,
  input  logic                 irq_ack,
  input  logic [ADDR_NBIT-1:0] pc_ret,
  input  logic                 eret,
  output logic [ADDR_NBIT-1:0] epc,
  output logic                 in_isr,
  output logic [NIRQ-1:0]      pending,
  output logic                 err
);

  localparam int                  SPW      = $clog2(NIRQ + 1);
  localparam logic [NBIT_IRQ-1:0] LVL_IDLE = NBIT_IRQ'(NIRQ);
  localparam logic [SPW-1:0]      SP_FULL  = SPW'(NIRQ);

  logic [NIRQ-1:0]      rise;
  logic [NIRQ-1:0]      pend_q;
  logic [NIRQ-1:0]      cand;
  logic [NIRQ-1:0]      clr;
  logic [SPW-1:0]       sp;
  logic [NBIT_IRQ-1:0]  cur_lvl;
  logic                 err_q;
  logic [NBIT_IRQ-1:0]  stk_lvl [NIRQ];
  logic [ADDR_NBIT-1:0] stk_epc [NIRQ];
  logic [NBIT_IRQ-1:0]  top_lvl;
  logic [ADDR_NBIT-1:0] top_epc;
  logic                 ack_ok;
  logic                 do_push;
  logic                 do_pop;
  logic                 bad;

  for (genvar g = 0; g < NIRQ; g++) begin : g_sync
    irq_edge_sync u_sync (
      .clk   (clk),
      .rst_n (rst_n),
      .src   (irq_src[g]),
      .rise  (rise[g])
    );
  end

  // Only lines strictly more urgent than the running level may preempt.
  always_comb begin
    cand     = '0;
    irq_inum = '0;
    for (int i = 0; i < NIRQ; i++) begin
      cand[i] = pend_q[i] & ~irq_mask[i] & (NBIT_IRQ'(i) < cur_lvl);
    end
    for (int i = NIRQ - 1; i >= 0; i--) begin
      if (cand[i]) irq_inum = NBIT_IRQ'(i);
    end
  end

  assign irq_req = irq_en & (|cand);

  always_comb begin
    top_lvl = LVL_IDLE;
    top_epc = '0;
    for (int i = 0; i < NIRQ; i++) begin
      if (sp == SPW'(i + 1)) begin
        top_lvl = stk_lvl[i];
        top_epc = stk_epc[i];
      end
    end
  end

  // eret takes precedence: a simultaneous ack is dropped without error and
  // the request is re-evaluated against the restored level next cycle.
  assign do_pop  = eret & (sp != '0);
  assign ack_ok  = irq_ack & ~eret & irq_req;
  assign do_push = ack_ok & (sp != SP_FULL);
  assign bad     = (eret & (sp == '0)) | (irq_ack & ~eret & ~irq_req) |
                   (ack_ok & (sp == SP_FULL));
  assign clr     = do_push ? (NIRQ'(1) << irq_inum) : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_q  <= '0;
      sp      <= '0;
      cur_lvl <= LVL_IDLE;
      err_q   <= 1'b0;
      for (int i = 0; i < NIRQ; i++) begin
        stk_lvl[i] <= '0;
        stk_epc[i] <= '0;
      end
    end else begin
      // a new edge on the line being acknowledged keeps it pending
      pend_q <= (pend_q & ~clr) | rise;
      if (bad) err_q <= 1'b1;
      if (do_pop) begin
        sp      <= sp - SPW'(1);
        cur_lvl <= top_lvl;
      end else if (do_push) begin
        sp      <= sp + SPW'(1);
        cur_lvl <= irq_inum;
        for (int i = 0; i < NIRQ; i++) begin
          if (sp == SPW'(i)) begin
            stk_lvl[i] <= cur_lvl;
            stk_epc[i] <= pc_ret;
          end
        end
      end
    end
  end

  assign epc     = (sp != '0) ? top_epc : '0;
  assign in_isr  = (sp != '0);
  assign pending = pend_q;
  assign err     = err_q;

endmodule

// File: tb/tb_irq_nest_ctrl.sv
// tb/tb_irq_nest_ctrl.sv - self-checking bench for irq_nest_ctrl
module tb_irq_nest_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [2:0] irq_src;
  logic       irq_en;
  logic [2:0] irq_mask;
  logic       irq_req;
  logic [1:0] irq_inum;
  logic       irq_ack;
  logic [9:0] pc_ret;
  logic       eret;
  logic [9:0] epc;
  logic       in_isr;
  logic [2:0] pending;
  logic       err;

  int nchecks = 0;
  int nfail   = 0;

  always #5 clk = ~clk;

  irq_nest_ctrl dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .irq_src  (irq_src),
    .irq_en   (irq_en),
    .irq_mask (irq_mask),
    .irq_req  (irq_req),
    .irq_inum (irq_inum),
    .irq_ack  (irq_ack),
    .pc_ret   (pc_ret),
    .eret     (eret),
    .epc      (epc),
    .in_isr   (in_isr),
    .pending  (pending),
    .err      (err)
  );

  typedef struct {
    logic [2:0] src;
    logic [2:0] mask;
    logic       en;
    logic       ack;
    logic [9:0] pc;
    logic       eret;
    logic       req;
    logic [1:0] inum;
    logic [9:0] epc;
    logic       isr;
    logic [2:0] pend;
    logic       err;
  } vec_t;

  typedef struct {
    logic       req;
    logic [1:0] inum;
    logic [9:0] epc;
    logic       isr;
    logic [2:0] pend;
    logic       err;
    string      tag;
  } exp_t;

  vec_t tbl[$];
  exp_t sb[$];

  function automatic vec_t v(input logic [2:0] src, input logic [2:0] mask,
                             input logic en, input logic ack,
                             input logic [9:0] pc, input logic er,
                             input logic req, input logic [1:0] inum,
                             input logic [9:0] e_epc, input logic isr,
                             input logic [2:0] pend, input logic e_err);
    vec_t r;
    r.src = src;  r.mask = mask; r.en = en;     r.ack = ack; r.pc = pc;   r.eret = er;
    r.req = req;  r.inum = inum; r.epc = e_epc; r.isr = isr; r.pend = pend; r.err = e_err;
    return r;
  endfunction

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nchecks++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endfunction

  task automatic push_exp(input vec_t r, input string tag);
    exp_t e;
    e.req = r.req; e.inum = r.inum; e.epc = r.epc; e.isr = r.isr;
    e.pend = r.pend; e.err = r.err; e.tag = tag;
    sb.push_back(e);
  endtask

  task automatic compare_front();
    exp_t e;
    nchecks++;
    if (sb.size() == 0) begin
      nfail++;
      $display("FAIL scoreboard_empty actual=0 expected=1");
    end else begin
      e = sb.pop_front();
      chk({e.tag, ".irq_req"},  32'(irq_req),  32'(e.req));
      chk({e.tag, ".irq_inum"}, 32'(irq_inum), 32'(e.inum));
      chk({e.tag, ".epc"},      32'(epc),      32'(e.epc));
      chk({e.tag, ".in_isr"},   32'(in_isr),   32'(e.isr));
      chk({e.tag, ".pending"},  32'(pending),  32'(e.pend));
      chk({e.tag, ".err"},      32'(err),      32'(e.err));
    end
  endtask

  // called at a negedge: drive, clock once, compare at the following negedge
  task automatic step(input vec_t r, input string tag);
    irq_src  = r.src;
    irq_mask = r.mask;
    irq_en   = r.en;
    irq_ack  = r.ack;
    pc_ret   = r.pc;
    eret     = r.eret;
    push_exp(r, tag);
    @(posedge clk);
    @(negedge clk);
    compare_front();
  endtask

  // asynchronous reset asserted mid-cycle, outputs checked before any edge
  task automatic mid_reset(input string tag);
    irq_ack = 1'b0;
    eret    = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    push_exp(v(3'b000, 3'b000, 1, 0, 10'h000, 0, 0, 2'd0, 10'h000, 0, 3'b000, 0), tag);
    compare_front();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic idle(input int n, input logic [2:0] src, input string tag);
    for (int i = 0; i < n; i++)
      step(v(src, 3'b000, 1, 0, 10'h000, 0, 0, 2'd0, 10'h000, 0, 3'b000, 0),
           $sformatf("%s%0d", tag, i));
  endtask

  initial begin
    rst_n    = 1'b0;
    irq_src  = '0;
    irq_mask = '0;
    irq_en   = 1'b1;
    irq_ack  = 1'b0;
    pc_ret   = '0;
    eret     = 1'b0;

    //            src     mask   en ack pc     eret  req inum  epc     isr pend   err
    tbl.push_back(v(3'b000,3'b000,1,0,10'h000,0, 0,2'd0,10'h000,0,3'b000,0));
    tbl.push_back(v(3'b000,3'b000,1,0,10'h000,0, 0,2'd0,10'h000,0,3'b000,0));
    tbl.push_back(v(3'b010,3'b000,1,0,10'h000,0, 0,2'd0,10'h000,0,3'b000,0));
    tbl.push_back(v(3'b000,3'b000,1,0,10'h000,0, 0,2'd0,10'h000,0,3'b000,0));
    tbl.push_back(v(3'b000,3'b000,1,0,10'h000,0, 1,2'd1,10'h000,0,3'b010,0));
    tbl.push_back(v(3'b000,3'b000,1,1,10'h040,0, 0,2'd0,10'h040,1,3'b000,0));
    tbl.push_back(v(3'b000,3'b000,1,0,10'h000,1, 0,2'd0,10'h000,0,3'b000,0));
    tbl.push_back(v(3'b111,3'b000,1,0,10'h000,0, 0,2'd0,10'h000,0,3'b000,0));
    tbl.push_back(v(3'b000,3'b000,1,0,10'h000,0, 0,2'd0,10'h000,0,3'b000,0));
    tbl.push_back(v(3'b000,3'b000,1,0,10'h000,0, 1,2'd0,10'h000,0,3'b111,0));
    tbl.push_back(v(3'b000,3'b000,1,1,10'h011,0, 0,2'd0,10'h011,1,3'b110,0));
    tbl.push_back(v(3'b000,3'b000,1,0,10'h000,1, 1,2'd1,10'h000,0,3'b110,0));
    tbl.push_back(v(3'b000,3'b000,1,1,10'h020,0, 0,2'd0,10'h020,1,3'b100,0));
    tbl.push_back(v(3'b000,3'b000,1,0,10'h000,1, 1,2'd2,10'h000,0,3'b100,0));
    tbl.push_back(v(3'b000,3'b000,1,1,10'h100,0, 0,2'd0,10'h100,1,3'b000,0));
    tbl.push_back(v(3'b001,3'b000,1,0,10'h000,0, 0,2'd0,10'h100,1,3'b000,0));
    tbl.push_back(v(3'b000,3'b000,1,0,10'h000,0, 0,2'd0,10'h100,1,3'b000,0));
    tbl.push_back(v(3'b000,3'b000,1,0,10'h000,0, 1,2'd0,10'h100,1,3'b001,0));
    tbl.push_back(v(3'b000,3'b000,1,1,10'h123,0, 0,2'd0,10'h123,1,3'b000,0));
    tbl.push_back(v(3'b000,3'b000,1,0,10'h000,1, 0,2'd0,10'h100,1,3'b000,0));
    tbl.push_back(v(3'b010,3'b000,1,0,10'h000,0, 0,2'd0,10'h100,1,3'b000,0));
    tbl.push_back(v(3'b000,3'b000,1,0,10'h000,0, 0,2'd0,10'h100,1,3'b000,0));
    tbl.push_back(v(3'b000,3'b000,1,0,10'h000,0, 1,2'd1,10'h100,1,3'b010,0));
    tbl.push_back(v(3'b000,3'b000,1,0,10'h000,1, 1,2'd1,10'h000,0,3'b010,0));
    tbl.push_back(v(3'b000,3'b000,1,1,10'h030,0, 0,2'd0,10'h030,1,3'b000,0));
    tbl.push_back(v(3'b000,3'b000,1,0,10'h000,1, 0,2'd0,10'h000,0,3'b000,0));
    tbl.push_back(v(3'b010,3'b010,1,0,10'h000,0, 0,2'd0,10'h000,0,3'b000,0));
    tbl.push_back(v(3'b000,3'b010,1,0,10'h000,0, 0,2'd0,10'h000,0,3'b000,0));
    tbl.push_back(v(3'b000,3'b010,1,0,10'h000,0, 0,2'd0,10'h000,0,3'b010,0));
    tbl.push_back(v(3'b000,3'b000,1,0,10'h000,0, 1,2'd1,10'h000,0,3'b010,0));
    tbl.push_back(v(3'b000,3'b000,0,0,10'h000,0, 0,2'd1,10'h000,0,3'b010,0));
    tbl.push_back(v(3'b001,3'b000,0,0,10'h000,0, 0,2'd1,10'h000,0,3'b010,0));
    tbl.push_back(v(3'b000,3'b000,0,0,10'h000,0, 0,2'd1,10'h000,0,3'b010,0));
    tbl.push_back(v(3'b000,3'b000,0,0,10'h000,0, 0,2'd0,10'h000,0,3'b011,0));
    tbl.push_back(v(3'b000,3'b000,1,0,10'h000,0, 1,2'd0,10'h000,0,3'b011,0));
    tbl.push_back(v(3'b000,3'b000,1,0,10'h000,1, 1,2'd0,10'h000,0,3'b011,1));

    repeat (2) @(negedge clk);
    push_exp(v(3'b000,3'b000,1,0,10'h000,0, 0,2'd0,10'h000,0,3'b000,0), "reset");
    compare_front();
    rst_n = 1'b1;

    for (int i = 0; i < tbl.size(); i++) step(tbl[i], $sformatf("row%0d", i));

    // reset clears the sticky error; then ack with no request
    mid_reset("rst_a");
    idle(3, 3'b000, "warm_a");
    step(v(3'b000,3'b000,1,1,10'h0EE,0, 0,2'd0,10'h000,0,3'b000,1), "ack_noreq");

    // ack and eret together at depth 1: only the pop happens
    mid_reset("rst_b");
    idle(3, 3'b000, "warm_b");
    step(v(3'b100,3'b000,1,0,10'h000,0, 0,2'd0,10'h000,0,3'b000,0), "b_src2");
    step(v(3'b000,3'b000,1,0,10'h000,0, 0,2'd0,10'h000,0,3'b000,0), "b_sync");
    step(v(3'b000,3'b000,1,0,10'h000,0, 1,2'd2,10'h000,0,3'b100,0), "b_pend2");
    step(v(3'b000,3'b000,1,1,10'h055,0, 0,2'd0,10'h055,1,3'b000,0), "b_ack2");
    step(v(3'b001,3'b000,1,0,10'h000,0, 0,2'd0,10'h055,1,3'b000,0), "b_src0");
    step(v(3'b000,3'b000,1,0,10'h000,0, 0,2'd0,10'h055,1,3'b000,0), "b_sync0");
    step(v(3'b000,3'b000,1,0,10'h000,0, 1,2'd0,10'h055,1,3'b001,0), "b_pend0");
    step(v(3'b000,3'b000,1,1,10'h077,1, 1,2'd0,10'h000,0,3'b001,0), "ack_eret");

    // build depth 2 (line 2 under mask of line 0, then line 0), reset mid-ISR
    step(v(3'b100,3'b000,1,0,10'h000,0, 1,2'd0,10'h000,0,3'b001,0), "c_src2");
    step(v(3'b000,3'b000,1,0,10'h000,0, 1,2'd0,10'h000,0,3'b001,0), "c_sync");
    step(v(3'b000,3'b000,1,0,10'h000,0, 1,2'd0,10'h000,0,3'b101,0), "c_pend");
    step(v(3'b000,3'b001,1,1,10'h0AA,0, 0,2'd0,10'h0AA,1,3'b001,0), "c_ack2");
    step(v(3'b000,3'b000,1,0,10'h000,0, 1,2'd0,10'h0AA,1,3'b001,0), "c_unmask");
    step(v(3'b000,3'b000,1,1,10'h0BB,0, 0,2'd0,10'h0BB,1,3'b000,0), "c_ack0");
    step(v(3'b010,3'b000,1,0,10'h000,0, 0,2'd0,10'h0BB,1,3'b000,0), "c_hold");
    mid_reset("rst_mid_isr");
    idle(5, 3'b010, "held");
    step(v(3'b000,3'b000,1,0,10'h000,0, 0,2'd0,10'h000,0,3'b000,0), "d_fall");
    step(v(3'b010,3'b000,1,0,10'h000,0, 0,2'd0,10'h000,0,3'b000,0), "d_rise");
    step(v(3'b000,3'b000,1,0,10'h000,0, 0,2'd0,10'h000,0,3'b000,0), "d_sync");
    step(v(3'b000,3'b000,1,0,10'h000,0, 1,2'd1,10'h000,0,3'b010,0), "d_pend");

    // new edge on line 1 lands in the same cycle its ack clears pending
    step(v(3'b010,3'b000,1,0,10'h000,0, 1,2'd1,10'h000,0,3'b010,0), "e_rise");
    step(v(3'b000,3'b000,1,0,10'h000,0, 1,2'd1,10'h000,0,3'b010,0), "e_sync");
    step(v(3'b000,3'b000,1,1,10'h0CC,0, 0,2'd0,10'h0CC,1,3'b010,0), "e_collide");

    $display("TB_RESULT checks=%0d failures=%0d", nchecks, nfail);
    $finish;
  end

endmodule
